// File: rtl/bench_acc.sv
// Load-edge accumulator with sticky overflow, attribute tag and saturating op count.
// Latency: one clock from oe or final load edge to outputs; no backpressure, one op per load rising edge.
// Outputs are registered and forced to zero whenever signal_oe is low.
module bench_acc #(
    parameter int DATA_WIDTH = 8,
    parameter int ATTR_WIDTH = 4,
    parameter int SIGN       = 0,
    parameter int OVERFLOW   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  signal_load,
    input  logic                  signal_init,
    input  logic                  signal_neg,
    input  logic                  signal_oe,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [ATTR_WIDTH-1:0] attr_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [ATTR_WIDTH-1:0] attr_out,
    output logic                  overflow,
    output logic                  valid,
    output logic [3:0]            op_cnt
);

    logic [DATA_WIDTH-1:0] acc_q, acc_d;
    logic [ATTR_WIDTH-1:0] tag_q, tag_d;
    logic                  ovf_q, ovf_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  load_q;

    logic [DATA_WIDTH-1:0] data_out_q;
    logic [ATTR_WIDTH-1:0] attr_out_q;
    logic                  overflow_q, valid_q;
    logic [3:0]            op_cnt_q;

    logic                  load_evt;
    logic [DATA_WIDTH:0]   sum_w, diff_w;
    logic [DATA_WIDTH-1:0] result_w;
    logic                  ovf_evt;

    assign load_evt = signal_load & ~load_q;
    assign sum_w    = {1'b0, acc_q} + {1'b0, data_in};
    assign diff_w   = {1'b0, acc_q} - {1'b0, data_in};
    assign result_w = signal_neg ? diff_w[DATA_WIDTH-1:0] : sum_w[DATA_WIDTH-1:0];

    // Unsigned uses carry/borrow out; signed compares operand and result sign bits.
    always_comb begin
        ovf_evt = 1'b0;
        if (SIGN != 0) begin
            if (signal_neg)
                ovf_evt = (acc_q[DATA_WIDTH-1] != data_in[DATA_WIDTH-1]) &&
                          (result_w[DATA_WIDTH-1] != acc_q[DATA_WIDTH-1]);
            else
                ovf_evt = (acc_q[DATA_WIDTH-1] == data_in[DATA_WIDTH-1]) &&
                          (result_w[DATA_WIDTH-1] != acc_q[DATA_WIDTH-1]);
        end else begin
            ovf_evt = signal_neg ? diff_w[DATA_WIDTH] : sum_w[DATA_WIDTH];
        end
    end

    always_comb begin
        acc_d = acc_q;
        tag_d = tag_q;
        ovf_d = ovf_q;
        cnt_d = cnt_q;
        if (signal_init) begin
            acc_d = '0;
            tag_d = attr_in;
            ovf_d = 1'b0;
            cnt_d = '0;
        end else if (load_evt) begin
            acc_d = result_w;
            ovf_d = ovf_q | ((OVERFLOW != 0) & ovf_evt);
            cnt_d = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q      <= '0;
            tag_q      <= '0;
            ovf_q      <= 1'b0;
            cnt_q      <= '0;
            load_q     <= 1'b0;
            data_out_q <= '0;
            attr_out_q <= '0;
            overflow_q <= 1'b0;
            valid_q    <= 1'b0;
            op_cnt_q   <= '0;
        end else begin
            acc_q  <= acc_d;
            tag_q  <= tag_d;
            ovf_q  <= ovf_d;
            cnt_q  <= cnt_d;
            load_q <= signal_load;
            if (signal_oe) begin
                data_out_q <= acc_d;
                attr_out_q <= tag_d;
                overflow_q <= ovf_d;
                valid_q    <= 1'b1;
                op_cnt_q   <= cnt_d;
            end else begin
                data_out_q <= '0;
                attr_out_q <= '0;
                overflow_q <= 1'b0;
                valid_q    <= 1'b0;
                op_cnt_q   <= '0;
            end
        end
    end

    assign data_out = data_out_q;
    assign attr_out = attr_out_q;
    assign overflow = overflow_q;
    assign valid    = valid_q;
    assign op_cnt   = op_cnt_q;

endmodule

// File: tb/tb_bench_acc.sv
// Directed bench for bench_acc: unsigned and signed instances share stimulus, checked against an integer model.
module tb_bench_acc;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       load = 1'b0, init = 1'b0, neg = 1'b0, oe = 1'b0;
    logic [7:0] din = '0;
    logic [3:0] ain = '0;

    logic [7:0] u_dout, s_dout;
    logic [3:0] u_attr, s_attr, u_cnt, s_cnt;
    logic       u_ovf, s_ovf, u_vld, s_vld;

    always #5 clk = ~clk;

    bench_acc #(.DATA_WIDTH(8), .ATTR_WIDTH(4), .SIGN(0), .OVERFLOW(1)) dut_u (
        .clk(clk), .rst_n(rst_n), .signal_load(load), .signal_init(init),
        .signal_neg(neg), .signal_oe(oe), .data_in(din), .attr_in(ain),
        .data_out(u_dout), .attr_out(u_attr), .overflow(u_ovf), .valid(u_vld), .op_cnt(u_cnt));

    bench_acc #(.DATA_WIDTH(8), .ATTR_WIDTH(4), .SIGN(1), .OVERFLOW(1)) dut_s (
        .clk(clk), .rst_n(rst_n), .signal_load(load), .signal_init(init),
        .signal_neg(neg), .signal_oe(oe), .data_in(din), .attr_in(ain),
        .data_out(s_dout), .attr_out(s_attr), .overflow(s_ovf), .valid(s_vld), .op_cnt(s_cnt));

    typedef struct packed {
        logic [7:0] d;
        logic [3:0] a;
        logic       o;
        logic       v;
        logic [3:0] c;
    } exp_t;

    exp_t q_u[$];
    exp_t q_s[$];
    int   checks = 0;
    int   errors = 0;

    int   m_acc_u, m_acc_s, m_ovf_u, m_ovf_s, m_tag, m_cnt, m_load_d;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_acc_u = 0; m_acc_s = 0; m_ovf_u = 0; m_ovf_s = 0;
        m_tag = 0; m_cnt = 0; m_load_d = 0;
        q_u.delete();
        q_s.delete();
    endtask

    task automatic check_all_zero(input string name);
        chk({name, "_u_all"}, {u_dout, u_attr, u_ovf, u_vld, u_cnt}, 0);
        chk({name, "_s_all"}, {s_dout, s_attr, s_ovf, s_vld, s_cnt}, 0);
    endtask

    task automatic pop_check();
        exp_t e;
        if (q_u.size() == 0 || q_s.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
            return;
        end
        e = q_u.pop_front();
        chk("u_data", u_dout, e.d);
        chk("u_attr", u_attr, e.a);
        chk("u_ovf",  u_ovf,  e.o);
        chk("u_vld",  u_vld,  e.v);
        chk("u_cnt",  u_cnt,  e.c);
        e = q_s.pop_front();
        chk("s_data", s_dout, e.d);
        chk("s_attr", s_attr, e.a);
        chk("s_ovf",  s_ovf,  e.o);
        chk("s_vld",  s_vld,  e.v);
        chk("s_cnt",  s_cnt,  e.c);
    endtask

    // Drive one cycle of stimulus, predict the registered outputs, then compare after the edge.
    task automatic cycle(input bit l, input bit i, input bit n, input bit o,
                         input int d, input int a);
        int   evt, r, sa, sd;
        exp_t eu, es;
        load = l; init = i; neg = n; oe = o; din = d[7:0]; ain = a[3:0];
        evt = (l && !m_load_d) ? 1 : 0;
        if (i) begin
            m_acc_u = 0; m_acc_s = 0; m_ovf_u = 0; m_ovf_s = 0; m_cnt = 0; m_tag = a;
        end else if (evt != 0) begin
            r = n ? m_acc_u - d : m_acc_u + d;
            if (r < 0 || r > 255) m_ovf_u = 1;
            m_acc_u = r & 255;
            sa = (m_acc_s > 127) ? m_acc_s - 256 : m_acc_s;
            sd = (d > 127) ? d - 256 : d;
            r  = n ? sa - sd : sa + sd;
            if (r < -128 || r > 127) m_ovf_s = 1;
            m_acc_s = r & 255;
            if (m_cnt < 15) m_cnt++;
        end
        m_load_d = l;
        if (o) begin
            eu = '{d: m_acc_u[7:0], a: m_tag[3:0], o: m_ovf_u[0], v: 1'b1, c: m_cnt[3:0]};
            es = '{d: m_acc_s[7:0], a: m_tag[3:0], o: m_ovf_s[0], v: 1'b1, c: m_cnt[3:0]};
        end else begin
            eu = '0;
            es = '0;
        end
        q_u.push_back(eu);
        q_s.push_back(es);
        @(posedge clk);
        #1;
        pop_check();
    endtask

    task automatic pulse(input bit n, input bit o, input int d, input int len);
        for (int k = 0; k < len; k++) cycle(1, 0, n, o, d, 0);
        cycle(0, 0, 0, o, d, 0);
    endtask

    initial begin
        model_reset();
        #12;
        check_all_zero("reset");
        rst_n = 1'b1;

        cycle(0, 1, 0, 0, 0, 0);
        pulse(0, 0, 4, 2);
        pulse(0, 0, 3, 2);
        pulse(1, 0, 5, 2);
        cycle(0, 0, 0, 1, 0, 0);
        chk("tp_basic_data", u_dout, 8'd2);
        chk("tp_basic_cnt",  u_cnt,  4'd3);
        chk("tp_basic_ovf",  u_ovf,  1'b0);
        chk("tp_basic_vld",  u_vld,  1'b1);

        cycle(0, 1, 0, 1, 0, 5);
        chk("init_oe_data", u_dout, 8'd0);
        chk("init_oe_attr", u_attr, 4'd5);
        pulse(0, 1, 2, 1);
        pulse(0, 1, 3, 1);
        pulse(0, 1, 2, 1);
        chk("track_data", u_dout, 8'd7);
        chk("track_cnt",  u_cnt,  4'd3);

        cycle(0, 1, 0, 1, 0, 3);
        for (int k = 0; k < 5; k++) cycle(1, 0, 0, 1, 1, 0);
        chk("hold_data", u_dout, 8'd1);
        chk("hold_cnt",  u_cnt,  4'd1);
        cycle(0, 0, 0, 1, 0, 0);

        cycle(0, 1, 0, 0, 0, 9);
        pulse(0, 0, 200, 1);
        pulse(0, 1, 100, 1);
        chk("u_wrap_data", u_dout, 8'd44);
        chk("u_wrap_ovf",  u_ovf,  1'b1);
        cycle(0, 1, 0, 1, 0, 9);
        chk("u_clear_ovf",  u_ovf,  1'b0);
        chk("u_clear_data", u_dout, 8'd0);

        pulse(0, 1, 100, 1);
        pulse(0, 1, 100, 1);
        chk("s_ovf_data", s_dout, 8'hC8);
        chk("s_ovf_flag", s_ovf,  1'b1);

        cycle(0, 1, 0, 1, 0, 2);
        pulse(1, 1, 1, 1);
        chk("u_borrow_data", u_dout, 8'd255);
        chk("u_borrow_ovf",  u_ovf,  1'b1);
        chk("s_neg1_ovf",    s_ovf,  1'b0);

        cycle(1, 1, 0, 1, 9, 6);
        cycle(1, 0, 0, 1, 9, 0);
        chk("init_prio_data", u_dout, 8'd0);
        cycle(0, 0, 0, 1, 0, 0);

        cycle(0, 1, 0, 1, 0, 1);
        for (int k = 0; k < 17; k++) pulse(0, 1, 1, 1);
        chk("sat_cnt", u_cnt, 4'd15);

        cycle(0, 0, 0, 0, 0, 0);
        chk("oe_off_data", u_dout, 8'd0);
        chk("oe_off_vld",  u_vld,  1'b0);

        cycle(0, 0, 0, 1, 0, 0);
        load = 1'b1;
        #2 rst_n = 1'b0;
        #1 check_all_zero("async_reset");
        model_reset();
        #2 rst_n = 1'b1;
        cycle(1, 0, 0, 1, 7, 0);
        chk("post_reset_data", u_dout, 8'd7);
        cycle(1, 0, 0, 1, 7, 0);
        chk("post_reset_hold", u_dout, 8'd7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bench_acc.md
Name: bench_acc

Overview:
- Load-driven accumulator datapath used as the arithmetic core of the bench subsystem.
- `signal_init` clears the accumulator and latches an attribute tag.
- Each rising edge of `signal_load` adds `data_in` to the accumulator, or subtracts it when `signal_neg` is high.
- `signal_oe` presents the result, the attribute tag, an overflow flag and an operation count on registered outputs.

Parameters:
- DATA_WIDTH, 8: width of the data operand, accumulator and data_out.
- ATTR_WIDTH, 4: width of the attribute tag (attr_in/attr_out).
- SIGN, 0: 0 = unsigned arithmetic; 1 = two's-complement arithmetic.
- OVERFLOW, 1: 1 = overflow detection enabled; 0 = overflow forced to 0, pure wrap-around.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- signal_load  input  1  level input; one accumulate operation per rising edge
- signal_init  input  1  synchronous clear / start of a new computation
- signal_neg  input  1  operation select sampled with the load edge (1 = subtract)
- signal_oe  input  1  output enable, level-sensitive
- data_in  input  DATA_WIDTH  operand
- attr_in  input  ATTR_WIDTH  attribute tag, latched on init
- data_out  output  DATA_WIDTH  accumulator result when enabled, else 0
- attr_out  output  ATTR_WIDTH  latched tag when enabled, else 0
- overflow  output  1  sticky overflow flag when enabled, else 0
- valid  output  1  high when outputs carry a result
- op_cnt  output  4  number of load operations since last init, saturating at 15

Behaviour:
- Reset (rst_n=0, asynchronous):
  - acc=0, tag=0, ovf_sticky=0, cnt=0, load_d=0.
  - All outputs 0.
- Load edge detect:
  - load_d is a register holding signal_load from the previous cycle.
  - load_evt = signal_load & ~load_d.
  - A load held high for N cycles performs exactly one operation.
  - One low sample between pulses is sufficient to re-arm.
- Init:
  - When signal_init=1 at a clock edge: acc<=0, ovf_sticky<=0, cnt<=0, tag<=attr_in.
  - Init has priority over a simultaneous load_evt; that load is discarded.
  - load_d still updates during init.
- Accumulate:
  - On load_evt without init, acc <= acc + data_in, or acc - data_in if signal_neg=1 at that edge.
  - The result is truncated to DATA_WIDTH (wrap-around).
  - cnt increments, saturating at 15.
  - signal_neg is ignored when load_evt=0.
- Overflow (only when OVERFLOW=1):
  - SIGN=0: set on carry-out of an add, or borrow of a subtract (data_in > acc).
  - SIGN=1: set when the two's-complement result sign is inconsistent with the operand signs (add: operands same sign, result differs; sub: operands differ in sign, result sign differs from acc).
  - Sticky until init or reset.
  - With OVERFLOW=0, overflow is constant 0.
- Output register, updated every clock edge:
  - If signal_oe=1:
    - data_out <= acc_next, the value after this edge's init/accumulate.
    - attr_out <= tag_next.
    - overflow <= ovf_next.
    - op_cnt <= cnt_next.
    - valid <= 1.
  - If signal_oe=0: all outputs <= 0 and valid <= 0.
  - Latency: one clock from oe (or from the final load edge) to output.
  - While oe stays high, outputs track the accumulator every cycle.
  - init with oe high gives data_out=0 and attr_out=attr_in on the next cycle.
- The accumulator is never modified by oe. Issuing oe without init continues the same accumulation.
- Reset mid-operation clears everything immediately. The first operation after reset needs a fresh load rising edge.

Test Plan:
- Reset then init with attr_in=0; load pulses of 2 cycles each with data 4, 3, then neg=1 with 5; oe=1 -> next cycle data_out=2, op_cnt=3, overflow=0, valid=1.
- With oe still high: init; loads 2, 3, 2 -> data_out steps 0,2,5,7; final data_out=7, op_cnt=3.
- Hold signal_load high 5 cycles with data_in=1 after init -> acc=1 (single operation), op_cnt=1.
- SIGN=0: init, load 200, load 100 -> data_out=44, overflow=1; then init -> overflow=0, data_out=0.
- SIGN=1: init, load 100, load 100 -> data_out=0xC8 (-56), overflow=1. SIGN=0: init, neg-load 1 -> data_out=255, overflow=1.
- init and load edge in the same cycle -> load ignored, acc=0. Assert rst_n=0 mid-sequence -> all outputs 0 asynchronously. oe=0 -> data_out=0, valid=0.
